// File: rtl/cpu_reset_pkg.sv
// rtl/cpu_reset_pkg.sv - shared types and sizing helper for the CPU reset sequencer
package cpu_reset_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_POR_REL,
        ST_RUN,
        ST_SW_RST
    } rst_state_t;

    // Counter must hold the largest interval without wrapping, plus one bit of headroom.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/cpu_reset_sequencer_if.sv
// rtl/cpu_reset_sequencer_if.sv - lock/request inputs and reset outputs of the CPU reset sequencer
interface cpu_reset_sequencer_if;

    logic locked;
    logic sw_reset_req;
    logic lock_lost_clr;
    logic por_resetn;
    logic sys_resetn;
    logic reset_busy;
    logic lock_lost;

    modport master (
        output locked, sw_reset_req, lock_lost_clr,
        input  por_resetn, sys_resetn, reset_busy, lock_lost
    );

    modport slave (
        input  locked, sw_reset_req, lock_lost_clr,
        output por_resetn, sys_resetn, reset_busy, lock_lost
    );

endinterface

// File: rtl/cdc_sync_bit.sv
// rtl/cdc_sync_bit.sv - single-bit multi-flop synchroniser with async active-low reset
module cdc_sync_bit #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/cpu_reset_sequencer.sv
// rtl/cpu_reset_sequencer.sv - sequences por/sys reset release from clock lock; re-enters reset on lock loss or sw request
module cpu_reset_sequencer
    import cpu_reset_pkg::*;
#(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int POR_EXTRA_CYCLES   = 16,
    parameter int SW_RESET_CYCLES    = 8
) (
    input  logic                        clk_cpu,
    input  logic                        resetn,
    cpu_reset_sequencer_if.slave        rst_if
);

    localparam int CNT_W = cnt_width(LOCK_STABLE_CYCLES, POR_EXTRA_CYCLES, SW_RESET_CYCLES);

    // Terminal values are one less than the interval: the exit edge is the interval's last cycle.
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] POR_LAST    = CNT_W'(POR_EXTRA_CYCLES - 1);
    localparam logic [CNT_W-1:0] SW_LAST     = CNT_W'(SW_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    rst_state_t       state_q;
    rst_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             locked_s;
    logic             por_d;
    logic             sys_d;
    logic             lost_set;
    logic             por_q;
    logic             sys_q;
    logic             busy_q;
    logic             lost_q;

    cdc_sync_bit #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_lock_sync (
        .clk   (clk_cpu),
        .rst_n (resetn),
        .d     (rst_if.locked),
        .q     (locked_s)
    );

    always_ff @(posedge clk_cpu or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_WAIT_LOCK;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_WAIT_LOCK: begin
                if (locked_s) state_d = ST_STABLE;
            end
            ST_STABLE: begin
                if (!locked_s)                 state_d = ST_WAIT_LOCK;
                else if (cnt_q == STABLE_LAST) state_d = ST_POR_REL;
            end
            ST_POR_REL: begin
                if (!locked_s)              state_d = ST_WAIT_LOCK;
                else if (cnt_q == POR_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                // Lock loss outranks a simultaneous software request.
                if (!locked_s)                 state_d = ST_WAIT_LOCK;
                else if (rst_if.sw_reset_req)  state_d = ST_SW_RST;
            end
            ST_SW_RST: begin
                if (!locked_s)             state_d = ST_WAIT_LOCK;
                else if (cnt_q == SW_LAST) state_d = ST_RUN;
            end
            default: state_d = ST_WAIT_LOCK;
        endcase
    end

    // One shared counter: cleared on every state change and in the untimed states, saturating otherwise.
    always_ff @(posedge clk_cpu or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if (state_d != state_q || state_q == ST_WAIT_LOCK || state_q == ST_RUN) begin
            cnt_q <= '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        por_d    = (state_d == ST_POR_REL) || (state_d == ST_RUN) || (state_d == ST_SW_RST);
        sys_d    = (state_d == ST_RUN);
        lost_set = !locked_s && ((state_q == ST_RUN) || (state_q == ST_SW_RST));
    end

    always_ff @(posedge clk_cpu or negedge resetn) begin
        if (!resetn) begin
            por_q  <= 1'b0;
            sys_q  <= 1'b0;
            busy_q <= 1'b1;
            lost_q <= 1'b0;
        end else begin
            por_q  <= por_d;
            sys_q  <= sys_d;
            busy_q <= !sys_d;
            if (lost_set) begin
                lost_q <= 1'b1;
            end else if (rst_if.lock_lost_clr) begin
                lost_q <= 1'b0;
            end
        end
    end

    assign rst_if.por_resetn = por_q;
    assign rst_if.sys_resetn = sys_q;
    assign rst_if.reset_busy = busy_q;
    assign rst_if.lock_lost  = lost_q;

endmodule

// File: tb/tb_cpu_reset_sequencer.sv
// tb/tb_cpu_reset_sequencer.sv - scoreboard bench for cpu_reset_sequencer with directed vectors
module tb_cpu_reset_sequencer;

    logic clk_cpu = 1'b0;
    logic resetn  = 1'b0;
    int   cyc     = 0;
    int   checks  = 0;
    int   errors  = 0;

    typedef struct {
        int         cyc;
        logic [3:0] val;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    cpu_reset_sequencer_if rst_if ();

    cpu_reset_sequencer #(
        .SYNC_STAGES        (2),
        .LOCK_STABLE_CYCLES (8),
        .POR_EXTRA_CYCLES   (4),
        .SW_RESET_CYCLES    (3)
    ) dut (
        .clk_cpu (clk_cpu),
        .resetn  (resetn),
        .rst_if  (rst_if)
    );

    always #5 clk_cpu = ~clk_cpu;

    always @(posedge clk_cpu) cyc <= cyc + 1;

    // Expected {por_resetn, sys_resetn, reset_busy, lock_lost} after posedge number c.
    task automatic expect_at(input int c, input bit por, input bit sys, input bit ll, input string nm);
        exp_t e;
        e.cyc  = c;
        e.val  = {por, sys, ~sys, ll};
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_cpu);
        #1;
    endtask

    always @(negedge clk_cpu) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (mon_e.cyc < cyc) begin
                errors++;
                $display("FAIL %s: not sampled at cycle %0d (now %0d)", mon_e.name, mon_e.cyc, cyc);
            end else if ({rst_if.por_resetn, rst_if.sys_resetn, rst_if.reset_busy, rst_if.lock_lost} !== mon_e.val) begin
                errors++;
                $display("FAIL %s: cycle %0d por/sys/busy/lost got %b required %b", mon_e.name, cyc,
                         {rst_if.por_resetn, rst_if.sys_resetn, rst_if.reset_busy, rst_if.lock_lost}, mon_e.val);
            end
        end
    end

    initial begin
        int r;
        int n;
        int t;
        int l;
        int m;

        rst_if.locked        = 1'b1;
        rst_if.sw_reset_req  = 1'b0;
        rst_if.lock_lost_clr = 1'b0;
        resetn               = 1'b0;

        // Power-up with lock held: locked_s at r+2, STABLE r+3..r+10, por at r+11, sys at r+15.
        tick(3);
        r = cyc;
        expect_at(r,      0, 0, 0, "reset_state");
        expect_at(r + 10, 0, 0, 0, "por_hold");
        expect_at(r + 11, 1, 0, 0, "por_rise");
        expect_at(r + 14, 1, 0, 0, "sys_hold");
        expect_at(r + 15, 1, 1, 0, "sys_rise");
        resetn = 1'b1;
        tick(16);

        // Software reset sampled at edge n: sys low n..n+2; a second request at n+2 is dropped.
        t = cyc;
        n = t + 1;
        expect_at(t,     1, 1, 0, "run_idle");
        expect_at(n,     1, 0, 0, "sw_low_first");
        expect_at(n + 2, 1, 0, 0, "sw_low_last");
        expect_at(n + 3, 1, 1, 0, "sw_release");
        expect_at(n + 4, 1, 1, 0, "sw_second_ignored");
        expect_at(n + 5, 1, 1, 0, "sw_run_steady");
        rst_if.sw_reset_req = 1'b1;
        tick(1);
        rst_if.sw_reset_req = 1'b0;
        tick(1);
        rst_if.sw_reset_req = 1'b1;
        tick(1);
        rst_if.sw_reset_req = 1'b0;
        tick(4);

        // Lock loss in RUN: seen on the edge after locked_s falls; relock repeats the sequence.
        t = cyc;
        expect_at(t + 2, 1, 1, 0, "lost_pre");
        expect_at(t + 3, 0, 0, 1, "lost_resets_low");
        rst_if.locked = 1'b0;
        tick(4);
        l = cyc;
        expect_at(l + 10, 0, 0, 1, "relock_por_hold");
        expect_at(l + 11, 1, 0, 1, "relock_por_rise");
        expect_at(l + 15, 1, 1, 1, "relock_sys_rise");
        expect_at(l + 16, 1, 1, 1, "lost_sticky");
        expect_at(l + 17, 1, 1, 0, "lost_cleared");
        rst_if.locked = 1'b1;
        tick(16);
        rst_if.lock_lost_clr = 1'b1;
        tick(1);
        rst_if.lock_lost_clr = 1'b0;
        tick(2);

        // Request and clear on the edge lock loss is acted on: WAIT_LOCK wins, set beats clear.
        t = cyc;
        rst_if.locked = 1'b0;
        tick(2);
        expect_at(t + 2, 1, 1, 0, "pre_drop");
        expect_at(t + 3, 0, 0, 1, "drop_beats_sw");
        expect_at(t + 4, 0, 0, 1, "drop_stays_wait");
        rst_if.sw_reset_req  = 1'b1;
        rst_if.lock_lost_clr = 1'b1;
        tick(1);
        rst_if.sw_reset_req  = 1'b0;
        rst_if.lock_lost_clr = 1'b0;
        tick(2);

        // Lock glitch while STABLE count is 5: counter restarts from the relock.
        l = cyc;
        rst_if.locked = 1'b1;
        tick(6);
        rst_if.locked = 1'b0;
        tick(3);
        m = cyc;
        expect_at(l + 11, 0, 0, 1, "restart_no_early_por");
        expect_at(m + 10, 0, 0, 1, "restart_por_hold");
        expect_at(m + 11, 1, 0, 1, "restart_por_rise");
        rst_if.locked = 1'b1;
        tick(12);

        // Mid POR_REL, drop resetn between edges; sampled before any further edge.
        #2;
        expect_at(m + 12, 0, 0, 0, "async_reset");
        expect_at(m + 14, 0, 0, 0, "reset_hold");
        resetn = 1'b0;
        tick(3);
        resetn = 1'b1;
        tick(2);

        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: never sampled (cycle %0d)", mon_e.name, mon_e.cyc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
